// File: rtl/conv_window_sched.sv
// Buffers one 6x6 image plus six 2x2 kernels, then streams all (k,r,c) windows over valid/ready; first window 1 cycle after the last beat.
// Window outputs hold while win_ready is low. Optional stall counter: CONV_WINDOW_SCHED_STALL_CNT_EN.
module conv_window_sched #(
    parameter int DIM   = 6,
    parameter int PIX_W = 3,
    parameter int N_KER = 6
) (
    input  logic                   clk2,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [DIM*PIX_W-1:0]   in_row,
    input  logic [4*PIX_W-1:0]     in_kernel,
    output logic                   busy,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [4*PIX_W-1:0]     win_data,
    output logic [4*PIX_W-1:0]     win_kernel,
    output logic                   win_last,
`ifdef CONV_WINDOW_SCHED_STALL_CNT_EN
    output logic [15:0]            stall_cnt,
`endif
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [2:0] LAST_BEAT = 3'(DIM - 1);
    localparam logic [2:0] LAST_POS  = 3'(DIM - 2);
    localparam logic [2:0] LAST_KER  = 3'(N_KER - 1);

    state_t state, state_nxt;
    logic [2:0] beat, k, r, c;
    logic [2:0] r1, c1;
    logic       done_q;
    logic       accept, xfer, at_last;

    logic [PIX_W-1:0]   pix  [DIM][DIM];
    logic [4*PIX_W-1:0] kbuf [N_KER];

    assign accept  = in_valid && (state != RUN);
    assign xfer    = win_valid && win_ready;
    assign at_last = (k == LAST_KER) && (r == LAST_POS) && (c == LAST_POS);
    assign r1      = r + 3'd1;
    assign c1      = c + 3'd1;
    assign done    = done_q;

    always_ff @(posedge clk2) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        win_valid  = 1'b0;
        win_data   = '0;
        win_kernel = '0;
        win_last   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) state_nxt = LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                if (in_valid && beat == LAST_BEAT) state_nxt = RUN;
            end
            RUN: begin
                busy       = 1'b1;
                win_valid  = 1'b1;
                win_data   = {pix[r1][c1], pix[r1][c], pix[r][c1], pix[r][c]};
                win_kernel = kbuf[k];
                win_last   = at_last;
                if (win_ready && at_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat counter restarts at 0 once the last row lands so the next pattern starts clean.
    always_ff @(posedge clk2) begin
        if (!rst_n) begin
            beat   <= '0;
            k      <= '0;
            r      <= '0;
            c      <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= xfer && at_last;
            if (accept) beat <= (beat == LAST_BEAT) ? 3'd0 : beat + 3'd1;
            if (xfer) begin
                if (c == LAST_POS) begin
                    c <= '0;
                    if (r == LAST_POS) begin
                        r <= '0;
                        k <= (k == LAST_KER) ? 3'd0 : k + 3'd1;
                    end else begin
                        r <= r + 3'd1;
                    end
                end else begin
                    c <= c + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk2) begin
        if (accept) begin
            for (int j = 0; j < DIM; j++) pix[beat][j] <= in_row[j*PIX_W +: PIX_W];
            kbuf[beat] <= in_kernel;
        end
    end

`ifdef CONV_WINDOW_SCHED_STALL_CNT_EN
    always_ff @(posedge clk2) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (in_valid && state == IDLE)
            stall_cnt <= '0;
        else if (win_valid && !win_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched: table of expected windows plus hand-written load/stall/reset sequences.
module tb_conv_window_sched;

    logic        clk2 = 1'b0;
    logic        rst_n, in_valid, win_ready;
    logic [17:0] in_row;
    logic [11:0] in_kernel;
    logic        busy, win_valid, win_last, done;
    logic [11:0] win_data, win_kernel;
`ifdef CONV_WINDOW_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    conv_window_sched dut (
        .clk2(clk2), .rst_n(rst_n), .in_valid(in_valid), .in_row(in_row),
        .in_kernel(in_kernel), .busy(busy), .win_valid(win_valid),
        .win_ready(win_ready), .win_data(win_data), .win_kernel(win_kernel),
        .win_last(win_last),
`ifdef CONV_WINDOW_SCHED_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .done(done)
    );

    always #5 clk2 = ~clk2;

    typedef struct {
        int          idx;
        logic [11:0] data;
        logic [11:0] ker;
        logic        last;
    } vec_t;

    vec_t        vt [10];
    logic [17:0] rows [6];
    logic [11:0] kers [6];
    logic [11:0] cap_data [150];
    logic [11:0] cap_ker  [150];
    logic        cap_last [150];
    int n_xfer, valid_cyc, run_cyc, stable_bad, gap_busy_bad;
    logic pre_vld, post_vld;
    int n_chk = 0;
    int n_fail = 0;

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // p(r,c) = (r+c) mod 8
    task automatic set_ord_pattern();
        for (int rr = 0; rr < 6; rr++) begin
            for (int cc = 0; cc < 6; cc++) rows[rr][cc*3 +: 3] = 3'((rr + cc) % 8);
            kers[rr] = 12'(rr);
        end
    endtask

    task automatic set_ones_pattern();
        for (int rr = 0; rr < 6; rr++) begin
            rows[rr] = 18'o111111;
            kers[rr] = 12'(rr);
        end
    endtask

    task automatic load(input int gap_after, input int gap_len);
        gap_busy_bad = 0;
        for (int b = 0; b < 6; b++) begin
            if (b == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    in_valid = 1'b0;
                    tick();
                    if (busy !== 1'b1) gap_busy_bad++;
                end
            end
            in_valid  = 1'b1;
            in_row    = rows[b];
            in_kernel = kers[b];
            if (b == 5) pre_vld = win_valid;
            tick();
        end
        in_valid = 1'b0;
        post_vld = win_valid;
    endtask

    task automatic collect(input int stall_at, input int abort_at, input bit poke);
        int cyc;
        int stalls;
        logic [11:0] held;
        n_xfer = 0; valid_cyc = 0; stable_bad = 0; cyc = 0; stalls = 0; held = '0;
        while (n_xfer < 150 && cyc < 2000) begin
            if (abort_at >= 0 && n_xfer == abort_at) begin
                run_cyc = cyc;
                return;
            end
            win_ready = !(n_xfer == stall_at && stalls < 5);
            in_valid  = poke && (cyc % 7 == 3);
            in_row    = '1;
            in_kernel = '1;
            if (win_valid) begin
                valid_cyc++;
                if (n_xfer == stall_at) begin
                    if (stalls == 0) held = win_data;
                    else if (win_data !== held) stable_bad++;
                end
                if (win_ready) begin
                    cap_data[n_xfer] = win_data;
                    cap_ker[n_xfer]  = win_kernel;
                    cap_last[n_xfer] = win_last;
                    n_xfer++;
                end else begin
                    stalls++;
                end
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        win_ready = 1'b1;
        run_cyc   = cyc;
        if (cyc >= 2000) chk("collect_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_done(input bit step);
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_win_valid", win_valid, 1'b0);
        if (step) begin
            tick();
            chk("done_one_cycle", done, 1'b0);
        end
    endtask

    initial begin
        int bad_d, bad_k, bad_l;
        vt[0] = '{0,   12'o2110, 12'd0, 1'b0};
        vt[1] = '{4,   12'o6554, 12'd0, 1'b0};
        vt[2] = '{5,   12'o3221, 12'd0, 1'b0};
        vt[3] = '{24,  12'o2110, 12'd0, 1'b0};
        vt[4] = '{25,  12'o2110, 12'd1, 1'b0};
        vt[5] = '{31,  12'o4332, 12'd1, 1'b0};
        vt[6] = '{62,  12'o6554, 12'd2, 1'b0};
        vt[7] = '{100, 12'o2110, 12'd4, 1'b0};
        vt[8] = '{148, 12'o1007, 12'd5, 1'b0};
        vt[9] = '{149, 12'o2110, 12'd5, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_row = '0; in_kernel = '0; win_ready = 1'b1;
        tick(); tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_win_valid", win_valid, 1'b0);
        chk("rst_win_data", win_data, 12'd0);
        chk("rst_win_kernel", win_kernel, 12'd0);
        chk("rst_win_last", win_last, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        tick();

        // Ordering with in_valid pokes during RUN
        set_ord_pattern();
        load(-1, 0);
        chk("ord_first_latency", post_vld, 1'b1);
        collect(-1, -1, 1'b1);
        chk("ord_xfers", n_xfer, 150);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("ord_data_%0d", vt[i].idx), cap_data[vt[i].idx], vt[i].data);
            chk($sformatf("ord_ker_%0d", vt[i].idx), cap_ker[vt[i].idx], vt[i].ker);
            chk($sformatf("ord_last_%0d", vt[i].idx), cap_last[vt[i].idx], vt[i].last);
        end
        chk_done(1'b0);

        // Beat 0 accepted in the done cycle
        set_ones_pattern();
        rows[0] = 18'o222222;
        load(-1, 0);
        chk("ovl_first_latency", post_vld, 1'b1);
        collect(-1, -1, 1'b0);
        chk("ovl_xfers", n_xfer, 150);
        chk("ovl_data_0", cap_data[0], 12'o1122);
        chk("ovl_data_5", cap_data[5], 12'o1111);
        chk_done(1'b1);

        // Back-to-back, ready tied high
        set_ones_pattern();
        load(-1, 0);
        collect(-1, -1, 1'b0);
        bad_d = 0; bad_k = 0; bad_l = 0;
        for (int i = 0; i < 150; i++) begin
            if (cap_data[i] !== 12'o1111) bad_d++;
            if (cap_ker[i] !== 12'(i / 25)) bad_k++;
            if (cap_last[i] !== (i == 149)) bad_l++;
        end
        chk("b2b_valid_cycles", valid_cyc, 150);
        chk("b2b_run_cycles", run_cyc, 150);
        chk("b2b_data_bad", bad_d, 0);
        chk("b2b_kernel_bad", bad_k, 0);
        chk("b2b_last_bad", bad_l, 0);
        chk_done(1'b1);

        // Backpressure at window 7
        set_ord_pattern();
        load(-1, 0);
        collect(7, -1, 1'b0);
        chk("bp_xfers", n_xfer, 150);
        chk("bp_valid_cycles", valid_cyc, 155);
        chk("bp_stable_bad", stable_bad, 0);
        chk("bp_data_7", cap_data[7], 12'o5443);
        chk("bp_data_8", cap_data[8], 12'o6554);
        chk_done(1'b1);
`ifdef CONV_WINDOW_SCHED_STALL_CNT_EN
        chk("bp_stall_cnt", stall_cnt, 16'd5);
        tick(); tick();
        chk("bp_stall_cnt_hold", stall_cnt, 16'd5);
`endif

        // Input gaps, then reset mid-RUN at window 40
        load(3, 4);
        chk("gap_busy_bad", gap_busy_bad, 0);
        chk("gap_pre_valid", pre_vld, 1'b0);
        chk("gap_first_latency", post_vld, 1'b1);
        collect(-1, 40, 1'b0);
        chk("abort_at_40", n_xfer, 40);
        rst_n = 1'b0;
        tick();
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_win_valid", win_valid, 1'b0);
        chk("mrst_win_data", win_data, 12'd0);
        chk("mrst_win_kernel", win_kernel, 12'd0);
        chk("mrst_win_last", win_last, 1'b0);
        chk("mrst_done", done, 1'b0);
`ifdef CONV_WINDOW_SCHED_STALL_CNT_EN
        chk("mrst_stall_cnt", stall_cnt, 16'd0);
`endif
        tick();
        rst_n = 1'b1;
        chk("mrst_busy2", busy, 1'b0);
        load(-1, 0);
        chk("restart_latency", post_vld, 1'b1);
        collect(-1, -1, 1'b0);
        chk("restart_xfers", n_xfer, 150);
        chk("restart_data_0", cap_data[0], 12'o2110);
        chk("restart_ker_0", cap_ker[0], 12'd0);
        chk("restart_data_31", cap_data[31], 12'o4332);
        chk_done(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
